// File: rtl/somador_subtrator_seq.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice per clock, LSB first.
// Result and flags update together when the last slice completes.
module somador_subtrator_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             OV,
    output logic             Z,
    output logic             N,
    output logic             busy,
    output logic             done
);

    localparam int NDIG = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if ((DIGIT < 1) || (WIDTH < 2) || (WIDTH % DIGIT != 0)) begin : g_bad_params
        $error("somador_subtrator_seq: invalid WIDTH/DIGIT combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT-1:0] a_sl;
    logic [DIGIT-1:0] b_sl;
    logic [DIGIT:0]   sum;
    logic [WIDTH-1:0] res;
    logic             c_msb;

    assign last = (cnt_q == CW'(NDIG - 1));
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign a_sl  = a_q[DIGIT-1:0];
    assign b_sl  = b_q[DIGIT-1:0];
    assign sum   = {1'b0, a_sl} + {1'b0, b_sl} + (DIGIT + 1)'(carry_q);
    // carry into the top bit of the slice, needed for OV on the last slice
    assign c_msb = a_sl[DIGIT-1] ^ b_sl[DIGIT-1] ^ sum[DIGIT-1];

    if (NDIG > 1) begin : g_multi
        logic [WIDTH-DIGIT-1:0] acc_q;

        assign res = {sum[DIGIT-1:0], acc_q};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)              acc_q <= '0;
            else if (state_q == RUN) acc_q <= res[WIDTH-1:DIGIT];
        end
    end else begin : g_single
        assign res = sum[DIGIT-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            S       <= '0;
            Cout    <= 1'b0;
            OV      <= 1'b0;
            Z       <= 1'b0;
            N       <= 1'b0;
        end else if (accept) begin
            a_q     <= A;
            b_q     <= op[0] ? ~B : B;
            carry_q <= op[1] ? cin : op[0];
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            carry_q <= sum[DIGIT];
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                S    <= res;
                Cout <= sum[DIGIT];
                OV   <= c_msb ^ sum[DIGIT];
                Z    <= (res == '0);
                N    <= res[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_somador_subtrator_seq.sv
// Directed bench: 8-bit bit-serial instance plus 16-bit radix-16 instance.
module tb_somador_subtrator_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic        cin;
    logic [7:0]  A, B, S;
    logic        Cout, OV, Z, N, busy, done;

    logic        start16;
    logic [1:0]  op16;
    logic        cin16;
    logic [15:0] A16, B16, S16;
    logic        Cout16, OV16, Z16, N16, busy16, done16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    somador_subtrator_seq #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cin(cin),
        .A(A), .B(B), .S(S), .Cout(Cout), .OV(OV), .Z(Z), .N(N),
        .busy(busy), .done(done)
    );

    somador_subtrator_seq #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .cin(cin16),
        .A(A16), .B(B16), .S(S16), .Cout(Cout16), .OV(OV16), .Z(Z16), .N(N16),
        .busy(busy16), .done(done16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive a request before the edge; return #1 after the accepting edge
    task automatic launch(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic c);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b; cin = c;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // count edges after the start edge until done is seen (99 = timeout)
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < 30) begin
            @(posedge clk);
            #1 n++;
        end
        if (done !== 1'b1) n = 99;
    endtask

    initial begin
        int n;
        int seen;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; cin = 1'b0; A = '0; B = '0;
        start16 = 1'b0; op16 = 2'b00; cin16 = 1'b0; A16 = '0; B16 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_S", 32'(S), 32'h0);
        chk("reset_flags", {Cout, OV, Z, N}, 4'b0000);
        chk("reset_busy_done", {busy, done}, 2'b00);
        @(negedge clk) rst_n = 1'b1;

        launch(2'b00, 8'h7F, 8'h01, 1'b0);
        chk("add7f_busy", 32'(busy), 32'h1);
        wait_done(0, n);
        chk("add7f_latency", n, 8);
        chk("add7f_S", 32'(S), 32'h80);
        chk("add7f_flags", {Cout, OV, Z, N}, 4'b0101);
        @(posedge clk) #1;
        chk("add7f_done_pulse", {busy, done}, 2'b00);
        chk("add7f_hold_S", 32'(S), 32'h80);

        launch(2'b00, 8'hFF, 8'h01, 1'b0);
        wait_done(0, n);
        chk("addff_S", 32'(S), 32'h00);
        chk("addff_flags", {Cout, OV, Z, N}, 4'b1010);

        launch(2'b01, 8'h05, 8'h07, 1'b0);
        wait_done(0, n);
        chk("sub_S", 32'(S), 32'hFE);
        chk("sub_flags", {Cout, OV, Z, N}, 4'b0001);

        launch(2'b10, 8'h10, 8'h20, 1'b1);
        wait_done(0, n);
        chk("adc_S", 32'(S), 32'h31);
        chk("adc_flags", {Cout, OV, Z, N}, 4'b0000);

        launch(2'b11, 8'h10, 8'h01, 1'b0);
        wait_done(0, n);
        chk("sbc_S", 32'(S), 32'h0E);
        chk("sbc_flags", {Cout, OV, Z, N}, 4'b1000);

        // new request while running must be ignored
        launch(2'b00, 8'h03, 8'h04, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 2'b01; A = 8'hAA; B = 8'h11; cin = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("ignore_busy", 32'(busy), 32'h1);
        wait_done(1, n);
        chk("ignore_latency", n, 8);
        chk("ignore_S", 32'(S), 32'h07);
        chk("ignore_flags", {Cout, OV, Z, N}, 4'b0000);
        @(posedge clk) #1;
        chk("ignore_no_restart", {busy, done}, 2'b00);

        // asynchronous abort mid-operation
        launch(2'b00, 8'h01, 8'h01, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("abort_S", 32'(S), 32'h0);
        chk("abort_flags", {Cout, OV, Z, N}, 4'b0000);
        chk("abort_busy_done", {busy, done}, 2'b00);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk) #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("abort_no_done", seen, 0);

        // back-to-back: re-start while in DONE
        launch(2'b00, 8'h11, 8'h22, 1'b0);
        wait_done(0, n);
        chk("b2b_first_S", 32'(S), 32'h33);
        start = 1'b1; op = 2'b00; A = 8'h40; B = 8'h40; cin = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b_direct_run", {busy, done}, 2'b10);
        wait_done(0, n);
        chk("b2b_latency", n, 8);
        chk("b2b_S", 32'(S), 32'h80);
        chk("b2b_flags", {Cout, OV, Z, N}, 4'b0101);

        // 16-bit, 4 bits per cycle
        @(negedge clk);
        start16 = 1'b1; op16 = 2'b01; A16 = 16'h8000; B16 = 16'h0001;
        @(posedge clk);
        #1 start16 = 1'b0;
        n = 0;
        while (done16 !== 1'b1 && n < 30) begin
            @(posedge clk);
            #1 n++;
        end
        chk("w16_latency", n, 4);
        chk("w16_S", 32'(S16), 32'h7FFF);
        chk("w16_flags", {Cout16, OV16, Z16, N16}, 4'b1100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
